// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and alignment helper for the data-memory port arbiter
package dmem_pkg;

    // Access sizes as presented on the RAM Size input
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Only the two low address bits matter: bytes are always aligned,
    // halfwords need bit 0 clear, word and doubleword-word need both clear.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - fetch, load/store and RAM signal bundle of the arbiter
// slave  : arbiter side (takes requests and ram_dout, drives acks, read data and RAM controls)
// master : environment side (requesters plus RAM)
interface dmem_port_arbiter_if;
    logic        i_req;
    logic [8:0]  i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_size;
    logic        d_sext;
    logic [8:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        ram_enable;
    logic        ram_rw;
    logic        ram_sext;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic [1:0]  ram_size;
    logic [31:0] ram_dout;

    modport slave (
        input  i_req, i_addr, d_req, d_rw, d_size, d_sext, d_addr, d_wdata, ram_dout,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               ram_enable, ram_rw, ram_sext, ram_addr, ram_din, ram_size
    );

    modport master (
        output i_req, i_addr, d_req, d_rw, d_size, d_sext, d_addr, d_wdata, ram_dout,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               ram_enable, ram_rw, ram_sext, ram_addr, ram_din, ram_size
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - data-priority winner select with fetch starvation counter
// Ports: clk, reset (async, active high); i_req, d_req pending requests;
//        grant strobe (a request is accepted this cycle); owner = current winner.
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t owner
);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       d_win;

    always_comb begin
        // Data normally wins; once fetch has lost STARVE_LIMIT times in a row it goes first.
        d_win        = d_req && !(i_req && (starve_cnt_q == 4'(STARVE_LIMIT)));
        owner        = d_win ? OWN_D : OWN_I;
        starve_cnt_d = starve_cnt_q;
        if (grant) begin
            if (d_win && i_req) begin
                starve_cnt_d = (starve_cnt_q == 4'(STARVE_LIMIT)) ? starve_cnt_q
                                                                  : starve_cnt_q + 4'd1;
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one 512x8 data RAM between fetch and load/store ports
// Ports: clk, reset (async, active high); bus (dmem_port_arbiter_if.slave) carries the fetch
//        port i_*, the load/store port d_* and the RAM controls ram_*.
// Optional: DMEM_ALIGN_CHECK_EN answers misaligned requests with ack+err and no RAM access.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus
);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      pick_owner;
    logic [8:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wait_q, wait_d;
    logic        en_q, en_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        i_err_q, i_err_d;
    logic        d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant;

    assign grant = (state_q == IDLE) && (bus.i_req || bus.d_req);

    dmem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .i_req (bus.i_req),
        .d_req (bus.d_req),
        .grant (grant),
        .owner (pick_owner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        size_d    = size_q;
        sext_d    = sext_q;
        wdata_d   = wdata_q;
        wait_d    = wait_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = pick_owner;
                    if (pick_owner == OWN_D) begin
                        addr_d  = bus.d_addr;
                        rw_d    = bus.d_rw;
                        size_d  = bus.d_size;
                        sext_d  = bus.d_sext;
                        wdata_d = bus.d_wdata;
                    end else begin
                        addr_d  = bus.i_addr;
                        rw_d    = 1'b0;
                        size_d  = SZ_WORD;
                        sext_d  = 1'b0;
                    end
                    wait_d  = 4'(ACCESS_CYCLES - 1);
                    state_d = ACCESS;
`ifdef DMEM_ALIGN_CHECK_EN
                    // Misaligned: skip the RAM entirely and answer with an error.
                    if (!is_aligned(size_d, addr_d[1:0])) begin
                        state_d = RESP;
                        i_ack_d = (pick_owner == OWN_I);
                        d_ack_d = (pick_owner == OWN_D);
                        i_err_d = (pick_owner == OWN_I);
                        d_err_d = (pick_owner == OWN_D);
                    end
`endif
                end
            end
            ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP;
                    if (owner_q == OWN_I) begin
                        i_ack_d = 1'b1;
                        if (!rw_q) i_rdata_d = bus.ram_dout;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!rw_q) d_rdata_d = bus.ram_dout;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Enable is registered against the next state so it covers exactly the ACCESS cycles.
        en_d = (state_d == ACCESS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            wdata_q   <= '0;
            wait_q    <= '0;
            en_q      <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            sext_q    <= sext_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            en_q      <= en_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Write strobe only while enabled; address/data/size keep their latched values between accesses.
    assign bus.ram_enable = en_q;
    assign bus.ram_rw     = en_q & rw_q;
    assign bus.ram_sext   = sext_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_din    = wdata_q;
    assign bus.ram_size   = size_q;
    assign bus.i_ack      = i_ack_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.i_err      = i_err_q;
    assign bus.d_err      = d_err_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
    import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct {
        bit        is_i;
        bit        rw;
        bit [1:0]  size;
        bit        sext;
        bit [8:0]  addr;
        bit [31:0] wdata;
        bit [31:0] exp_rdata;
        bit        mis;
    } vec_t;

    typedef struct {
        bit        is_d;
        bit [31:0] rdata;
        bit        err;
    } exp_t;

    logic clk;
    logic rst1;
    logic rst3;
    int   checks;
    int   errors;
    logic [7:0] mem [2][512];
    exp_t sb1[$];
    exp_t sb3[$];
    bit [31:0] last_i;
    bit [31:0] last_d;
    vec_t vecs[14];

    dmem_port_arbiter_if bus1();
    dmem_port_arbiter_if bus3();

    dmem_port_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    dmem_port_arbiter #(.ACCESS_CYCLES(3), .STARVE_LIMIT(4)) u_dut3 (
        .clk   (clk),
        .reset (rst3),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ram_rd(input int k, input logic [8:0] a,
                                           input logic [1:0] sz, input logic sx);
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[k][a];
        b1 = mem[k][a + 9'd1];
        b2 = mem[k][a + 9'd2];
        b3 = mem[k][a + 9'd3];
        case (sz)
            2'b00:   return sx ? {{24{b0[7]}}, b0} : {24'd0, b0};
            2'b01:   return sx ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic ram_wr(input int k, input logic [8:0] a, input logic [1:0] sz,
                          input logic [31:0] d);
        mem[k][a] = d[7:0];
        if (sz != 2'b00) mem[k][a + 9'd1] = d[15:8];
        if (sz[1]) begin
            mem[k][a + 9'd2] = d[23:16];
            mem[k][a + 9'd3] = d[31:24];
        end
    endtask

    // RAM model: level-sensitive write while enabled, combinational read, evaluated mid-cycle.
    always @(negedge clk) begin
        if (bus1.ram_enable && bus1.ram_rw) ram_wr(0, bus1.ram_addr, bus1.ram_size, bus1.ram_din);
        if (bus3.ram_enable && bus3.ram_rw) ram_wr(1, bus3.ram_addr, bus3.ram_size, bus3.ram_din);
        bus1.ram_dout = ram_rd(0, bus1.ram_addr, bus1.ram_size, bus1.ram_sext);
        bus3.ram_dout = ram_rd(1, bus3.ram_addr, bus3.ram_size, bus3.ram_sext);
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (!rst1 && (bus1.i_ack || bus1.d_ack)) begin
            chk("ack1_exclusive", 32'(bus1.i_ack & bus1.d_ack), 32'd0);
            if (sb1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack1_unexpected: got i_ack=%0b d_ack=%0b expected no ack", bus1.i_ack, bus1.d_ack);
            end else begin
                e = sb1.pop_front();
                chk("ack1_owner", 32'(bus1.d_ack), 32'(e.is_d));
                if (e.is_d) begin
                    chk("d_rdata1", bus1.d_rdata, e.rdata);
                    chk("d_err1", 32'(bus1.d_err), 32'(e.err));
                end else begin
                    chk("i_rdata1", bus1.i_rdata, e.rdata);
                    chk("i_err1", 32'(bus1.i_err), 32'(e.err));
                end
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (!rst3 && (bus3.i_ack || bus3.d_ack)) begin
            chk("ack3_exclusive", 32'(bus3.i_ack & bus3.d_ack), 32'd0);
            if (sb3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack3_unexpected: got i_ack=%0b d_ack=%0b expected no ack", bus3.i_ack, bus3.d_ack);
            end else begin
                e = sb3.pop_front();
                chk("ack3_owner", 32'(bus3.d_ack), 32'(e.is_d));
                chk("i_rdata3", bus3.i_rdata, e.rdata);
                chk("i_err3", 32'(bus3.i_err), 32'(e.err));
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   edges;
        int   en_cnt;
        bit   got;
        bit   mis_eff;
        mis_eff = ALIGN_EN && v.mis;
        e.is_d  = !v.is_i;
        e.err   = mis_eff;
        if (mis_eff || v.rw) e.rdata = v.is_i ? last_i : last_d;
        else                 e.rdata = v.exp_rdata;
        if (v.is_i) last_i = e.rdata;
        else        last_d = e.rdata;
        sb1.push_back(e);
        if (v.is_i) begin
            bus1.i_addr = v.addr;
            bus1.i_req  = 1'b1;
        end else begin
            bus1.d_rw    = v.rw;
            bus1.d_size  = v.size;
            bus1.d_sext  = v.sext;
            bus1.d_addr  = v.addr;
            bus1.d_wdata = v.wdata;
            bus1.d_req   = 1'b1;
        end
        edges  = 0;
        en_cnt = 0;
        got    = 1'b0;
        while (!got && edges < 16) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus1.ram_enable) begin
                en_cnt++;
                chk("ram_addr", 32'(bus1.ram_addr), 32'(v.addr));
                chk("ram_rw", 32'(bus1.ram_rw), v.is_i ? 32'd0 : 32'(v.rw));
                chk("ram_size", 32'(bus1.ram_size), v.is_i ? 32'd2 : 32'(v.size));
                if (v.rw) chk("ram_din", bus1.ram_din, v.wdata);
            end
            got = bus1.i_ack || bus1.d_ack;
        end
        chk("ack_latency", 32'(edges), mis_eff ? 32'd1 : 32'd2);
        chk("ram_en_cycles", 32'(en_cnt), mis_eff ? 32'd0 : 32'd1);
        bus1.i_req = 1'b0;
        bus1.d_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int edges;
        int acks;
        int en_cnt;
        bit got;
        checks = 0;
        errors = 0;
        last_i = '0;
        last_d = '0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_rw = 0;
        bus1.d_size = '0; bus1.d_sext = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus3.i_req = 0; bus3.i_addr = '0; bus3.d_req = 0; bus3.d_rw = 0;
        bus3.d_size = '0; bus3.d_sext = 0; bus3.d_addr = '0; bus3.d_wdata = '0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 512; a++) mem[k][a] = 8'h00;
        mem[0][4] = 8'h0D; mem[0][5] = 8'h0C; mem[0][6] = 8'h0B; mem[0][7] = 8'h0A;
        mem[0][8] = 8'h11; mem[0][9] = 8'h22; mem[0][10] = 8'h33; mem[0][11] = 8'h44;
        mem[1][0] = 8'h78; mem[1][1] = 8'h56; mem[1][2] = 8'h34; mem[1][3] = 8'h12;

        //          is_i rw  size   sext addr     wdata         exp_rdata     mis
        vecs[0]  = '{0, 0, 2'b10, 0, 9'h004, 32'h0,        32'h0A0B0C0D, 0};
        vecs[1]  = '{0, 1, 2'b01, 0, 9'h002, 32'h0000BBCC, 32'h0,        0};
        vecs[2]  = '{0, 0, 2'b01, 1, 9'h002, 32'h0,        32'hFFFFBBCC, 0};
        vecs[3]  = '{0, 0, 2'b01, 0, 9'h002, 32'h0,        32'h0000BBCC, 0};
        vecs[4]  = '{0, 0, 2'b00, 1, 9'h005, 32'h0,        32'h0000000C, 0};
        vecs[5]  = '{0, 0, 2'b00, 1, 9'h003, 32'h0,        32'hFFFFFFBB, 0};
        vecs[6]  = '{0, 1, 2'b00, 0, 9'h010, 32'h000000F0, 32'h0,        0};
        vecs[7]  = '{0, 0, 2'b00, 1, 9'h010, 32'h0,        32'hFFFFFFF0, 0};
        vecs[8]  = '{0, 1, 2'b10, 0, 9'h020, 32'hDEADBEEF, 32'h0,        0};
        vecs[9]  = '{0, 0, 2'b11, 0, 9'h020, 32'h0,        32'hDEADBEEF, 0};
        vecs[10] = '{1, 0, 2'b10, 0, 9'h004, 32'h0,        32'h0A0B0C0D, 0};
        vecs[11] = '{0, 0, 2'b10, 0, 9'h006, 32'h0,        32'h22110A0B, 1};
        vecs[12] = '{0, 0, 2'b01, 0, 9'h001, 32'h0,        32'h0000CC00, 1};
        vecs[13] = '{1, 0, 2'b10, 0, 9'h002, 32'h0,        32'h0C0DBBCC, 1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_ack", 32'(bus1.i_ack), 32'd0);
        chk("rst_d_ack", 32'(bus1.d_ack), 32'd0);
        chk("rst_i_err", 32'(bus1.i_err), 32'd0);
        chk("rst_d_err", 32'(bus1.d_err), 32'd0);
        chk("rst_ram_enable", 32'(bus1.ram_enable), 32'd0);
        chk("rst_ram_rw", 32'(bus1.ram_rw), 32'd0);
        chk("rst_i_rdata", bus1.i_rdata, 32'd0);
        chk("rst_d_rdata", bus1.d_rdata, 32'd0);
        chk("rst_ram_addr", 32'(bus1.ram_addr), 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk);
        #1;

        for (int n = 0; n < 14; n++) run_vec(vecs[n]);

        // Both requesters held high: data wins four times, then fetch is forced through.
        for (int n = 0; n < 10; n++) begin
            if (n % 5 == 4) begin
                sb1.push_back('{is_d: 1'b0, rdata: 32'h0A0B0C0D, err: 1'b0});
                last_i = 32'h0A0B0C0D;
            end else begin
                sb1.push_back('{is_d: 1'b1, rdata: 32'hDEADBEEF, err: 1'b0});
                last_d = 32'hDEADBEEF;
            end
        end
        bus1.i_addr = 9'h004;
        bus1.d_addr = 9'h020; bus1.d_rw = 0; bus1.d_size = 2'b10; bus1.d_sext = 0;
        bus1.i_req = 1'b1;
        bus1.d_req = 1'b1;
        edges = 0;
        acks  = 0;
        while (acks < 10 && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus1.i_ack || bus1.d_ack) acks++;
        end
        bus1.i_req = 1'b0;
        bus1.d_req = 1'b0;
        chk("starve_acks", 32'(acks), 32'd10);
        chk("starve_edges", 32'(edges), 32'd29);
        repeat (3) @(posedge clk);
        #1;
        chk("sb1_drained", 32'(sb1.size()), 32'd0);

        // Three wait states: fetch from 0x000.
        sb3.push_back('{is_d: 1'b0, rdata: 32'h12345678, err: 1'b0});
        bus3.i_addr = 9'h000;
        bus3.i_req  = 1'b1;
        edges  = 0;
        en_cnt = 0;
        got    = 1'b0;
        while (!got && edges < 16) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus3.ram_enable) begin
                en_cnt++;
                chk("ram3_addr", 32'(bus3.ram_addr), 32'd0);
                chk("ram3_size", 32'(bus3.ram_size), 32'd2);
                chk("ram3_rw", 32'(bus3.ram_rw), 32'd0);
            end
            got = bus3.i_ack || bus3.d_ack;
        end
        bus3.i_req = 1'b0;
        chk("ac3_latency", 32'(edges), 32'd4);
        chk("ac3_en_cycles", 32'(en_cnt), 32'd3);
        @(posedge clk);
        #1;

        // Reset in the middle of an access abandons it.
        bus3.i_addr = 9'h008;
        bus3.i_req  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_access_en", 32'(bus3.ram_enable), 32'd1);
        rst3 = 1'b1;
        #1;
        chk("rst3_ram_enable", 32'(bus3.ram_enable), 32'd0);
        chk("rst3_i_ack", 32'(bus3.i_ack), 32'd0);
        chk("rst3_d_ack", 32'(bus3.d_ack), 32'd0);
        chk("rst3_state", 32'(u_dut3.state_q), 32'(IDLE));
        chk("rst3_i_rdata", bus3.i_rdata, 32'd0);
        bus3.i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst3_en", 32'(bus3.ram_enable), 32'd0);
        chk("post_rst3_state", 32'(u_dut3.state_q), 32'(IDLE));
        chk("sb3_drained", 32'(sb3.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single 512x8 data memory (ram_512x8) between the instruction-fetch port and the load/store port.
- Sequences each access through a request/acknowledge handshake.
- Fixed priority goes to the data port, with a starvation guard for fetch.
- Sits between the pipeline front/memory stages and the RAM; the RAM read path is combinational, its write is level-sensitive on Enable.

Parameters:
- ACCESS_CYCLES, 1: cycles the RAM is enabled per access (wait states); legal range 1..15.
- STARVE_LIMIT, 4: consecutive data grants allowed while i_req is pending before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  9  fetch byte address (word read)
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetched word; valid when i_ack=1
- i_err  out  1  fetch misaligned; valid with i_ack
- d_req  in  1  load/store request; held until d_ack
- d_rw  in  1  0=read, 1=write
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 doubleword-word
- d_sext  in  1  sign-extend loaded byte/halfword
- d_addr  in  9  data byte address
- d_wdata  in  32  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  32  load data; valid when d_ack=1 and d_rw=0
- d_err  out  1  data misaligned; valid with d_ack
- ram_enable  out  1  to RAM Enable
- ram_rw  out  1  to RAM ReadWrite
- ram_sext  out  1  to RAM SignExtend
- ram_addr  out  9  to RAM Address
- ram_din  out  32  to RAM DataIn
- ram_size  out  2  to RAM Size
- ram_dout  in  32  from RAM DataOut

Behaviour:
- Reset (async): state=IDLE; all acks/errs 0; ram_enable=0, ram_rw=0; i_rdata=d_rdata=0; latched request fields 0; starve_cnt=0. An access in flight is abandoned.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick the winner, latch owner/addr/rw/size/sext/wdata into registers, load wait_cnt=ACCESS_CYCLES-1, go to ACCESS.
  - Fetch is latched as rw=0, size=10, sext=0.
- Winner rule:
  - Data wins if d_req=1, unless i_req=1 and starve_cnt==STARVE_LIMIT, in which case fetch wins.
  - Fetch wins if only i_req=1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a data grant with i_req=1.
  - Clears on a fetch grant, or on a data grant with i_req=0.
- ACCESS:
  - ram_enable=1; RAM inputs come only from latched registers and stay stable for every ACCESS cycle, so level-sensitive writes are safe.
  - Decrement wait_cnt each cycle.
  - When wait_cnt==0: capture ram_dout into the owner's rdata register (reads only), go to RESP.
- RESP:
  - ram_enable=0; owner's ack=1 for exactly one cycle; go to IDLE.
  - rdata holds until the next read completion for that port; writes leave d_rdata unchanged.
- Outside ACCESS: ram_enable=0, ram_rw=0; address/data/size hold their latched values.
- Requester handshake:
  - A requester drops req the cycle after its ack. A req still high in IDLE is a new request.
  - Inputs are sampled only in IDLE; changes while not in IDLE are ignored.
- Latency: request-to-ack = ACCESS_CYCLES+2 cycles. Back-to-back throughput is one access per ACCESS_CYCLES+2 cycles.
- Simultaneous i_req and d_req in IDLE: resolved by the winner rule. The loser waits with no ack and no error.
- Only one ack may be high in any cycle.

Optional Feature:
- Macro name: DMEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, the winner's alignment is checked. Halfword requires addr[0]=0; word and doubleword require addr[1:0]=00; fetch requires addr[1:0]=00.
  - A misaligned request is granted and counts for starve_cnt, but goes IDLE->RESP directly with no RAM enable.
  - RESP then asserts ack together with err=1; rdata is unchanged.
- Undefined: i_err=d_err=0 constantly; addresses pass unchecked.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10, SZ_DWORD=11);
  - FSM state encodings (IDLE, ACCESS, RESP);
  - owner encodings (OWN_I, OWN_D);
  - alignment check function.
- One sub-module, dmem_arb_pick: winner selection plus the starve_cnt register (inputs: i_req, d_req, grant strobe).

Test Plan:
- Reset, then d_req=1, d_rw=0, d_size=10, d_addr=0x004, with RAM preloaded 0x0A0B0C0D at word 4, ACCESS_CYCLES=1 → d_ack exactly at cycle 3 after request, d_rdata=0x0A0B0C0D, i_ack stays 0.
- d_rw=1, d_size=01, d_addr=0x002, d_wdata=0x0000BBCC, then read back size=01, sext=1 → ram_enable high exactly one cycle with stable inputs; readback d_rdata=0xFFFFBBCC.
- i_req and d_req both held high continuously, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I; one ack per access, never both acks high.
- ACCESS_CYCLES=3, fetch addr 0x000 → ram_enable high 3 cycles, i_ack at cycle 5; async reset pulsed during ACCESS → ram_enable and acks drop immediately, FSM=IDLE, no ack issued.
- With DMEM_ALIGN_CHECK_EN: d_size=10, d_addr=0x006 → d_ack=1 with d_err=1 two cycles after request, ram_enable never asserts. Without the macro: same request → RAM accessed, d_err=0.
